// File: rtl/teclado_matricial.sv
// 4x4 active-low matrix keypad scanner: column scan, row synchronizer,
// press/release debounce and key encoding with a single pulse per press.
module teclado_matricial #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] linhas,
    output logic [3:0] colunas,
    output logic       tecla_ativada,
    output logic [3:0] digito,
    output logic       eh_digito
);

    localparam int unsigned ScanW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DebW  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEBOUNCE - 1);

    typedef enum logic [1:0] {
        StVarre,
        StFiltra,
        StPulso,
        StSolta
    } state_e;

    state_e           state_q;
    logic [3:0]       sync1_q;
    logic [3:0]       lin_s;
    logic [1:0]       col_idx_q;
    logic [1:0]       row_q;
    logic [3:0]       pat_q;
    logic [ScanW-1:0] scan_cnt_q;
    logic [DebW-1:0]  deb_cnt_q;

    logic [1:0] low_row;
    logic [3:0] key_code;
    logic [1:0] col_next;

    function automatic logic [3:0] col_mask(input logic [1:0] idx);
        col_mask = ~(4'b0001 << idx);
    endfunction

    assign col_next = col_idx_q + 2'd1;

    // Lowest-index low row wins when several rows of one column are low.
    always_comb begin
        low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!lin_s[i]) begin
                low_row = 2'(i);
            end
        end
    end

    always_comb begin
        key_code = 4'd0;
        unique case ({row_q, col_idx_q})
            4'b00_00: key_code = 4'd1;
            4'b00_01: key_code = 4'd2;
            4'b00_10: key_code = 4'd3;
            4'b00_11: key_code = 4'd10;
            4'b01_00: key_code = 4'd4;
            4'b01_01: key_code = 4'd5;
            4'b01_10: key_code = 4'd6;
            4'b01_11: key_code = 4'd11;
            4'b10_00: key_code = 4'd7;
            4'b10_01: key_code = 4'd8;
            4'b10_10: key_code = 4'd9;
            4'b10_11: key_code = 4'd12;
            4'b11_00: key_code = 4'd14;
            4'b11_01: key_code = 4'd0;
            4'b11_10: key_code = 4'd15;
            4'b11_11: key_code = 4'd13;
            default:  key_code = 4'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StVarre;
            sync1_q       <= 4'b1111;
            lin_s         <= 4'b1111;
            col_idx_q     <= 2'd0;
            row_q         <= 2'd0;
            pat_q         <= 4'b1111;
            scan_cnt_q    <= '0;
            deb_cnt_q     <= '0;
            colunas       <= 4'b1110;
            tecla_ativada <= 1'b0;
            digito        <= 4'd0;
            eh_digito     <= 1'b0;
        end else begin
            sync1_q       <= linhas;
            lin_s         <= sync1_q;
            tecla_ativada <= 1'b0;

            unique case (state_q)
                StVarre: begin
                    if (scan_cnt_q == ScanLast) begin
                        scan_cnt_q <= '0;
                        if (lin_s == 4'b1111) begin
                            col_idx_q <= col_next;
                            colunas   <= col_mask(col_next);
                        end else begin
                            pat_q     <= lin_s;
                            row_q     <= low_row;
                            deb_cnt_q <= '0;
                            state_q   <= StFiltra;
                        end
                    end else begin
                        scan_cnt_q <= scan_cnt_q + 1'b1;
                    end
                end

                // Any deviation from the latched pattern restarts the scan slot.
                StFiltra: begin
                    if (lin_s == pat_q) begin
                        if (deb_cnt_q == DebLast) begin
                            state_q       <= StPulso;
                            tecla_ativada <= 1'b1;
                            digito        <= key_code;
                            eh_digito     <= (key_code <= 4'd9);
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end else begin
                        state_q    <= StVarre;
                        scan_cnt_q <= '0;
                        deb_cnt_q  <= '0;
                    end
                end

                StPulso: begin
                    state_q   <= StSolta;
                    deb_cnt_q <= '0;
                end

                StSolta: begin
                    if (lin_s == 4'b1111) begin
                        if (deb_cnt_q == DebLast) begin
                            state_q    <= StVarre;
                            deb_cnt_q  <= '0;
                            scan_cnt_q <= '0;
                            col_idx_q  <= col_next;
                            colunas    <= col_mask(col_next);
                        end else begin
                            deb_cnt_q <= deb_cnt_q + 1'b1;
                        end
                    end else begin
                        deb_cnt_q <= '0;
                    end
                end

                default: state_q <= StVarre;
            endcase
        end
    end

endmodule

// File: tb/tb_teclado_matricial.sv
// Directed bench for teclado_matricial with SCAN_DIV=4, DEBOUNCE=8 and a
// keypad model that pulls a row low when its key is pressed and its column is low.
module tb_teclado_matricial;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] linhas;
    logic [3:0] colunas;
    logic       tecla_ativada;
    logic [3:0] digito;
    logic       eh_digito;

    logic [15:0] pressed = '0;
    int checks = 0;
    int passes = 0;
    int fails = 0;
    int pulse_cnt = 0;
    int base;
    int n;

    always #5 clk = ~clk;

    teclado_matricial #(
        .SCAN_DIV(4),
        .DEBOUNCE(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .linhas       (linhas),
        .colunas      (colunas),
        .tecla_ativada(tecla_ativada),
        .digito       (digito),
        .eh_digito    (eh_digito)
    );

    always_comb begin
        linhas = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && colunas[c] == 1'b0) begin
                    linhas[r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (tecla_ativada === 1'b1) pulse_cnt++;
    end

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int key(input int r, input int c);
        return r * 4 + c;
    endfunction

    initial begin
        // 1. reset and idle scan
        cyc(3);
        check("rst_colunas", 32'(colunas), 32'd14);
        check("rst_pulse", 32'(tecla_ativada), 32'd0);
        check("rst_digito", 32'(digito), 32'd0);
        check("rst_eh_digito", 32'(eh_digito), 32'd0);
        reset = 1'b0;
        cyc(1); check("scan_c0_first", 32'(colunas), 32'd14);
        cyc(2); check("scan_c0_last", 32'(colunas), 32'd14);
        cyc(1); check("scan_c1", 32'(colunas), 32'd13);
        cyc(4); check("scan_c2", 32'(colunas), 32'd11);
        cyc(4); check("scan_c3", 32'(colunas), 32'd7);
        cyc(4); check("scan_wrap", 32'(colunas), 32'd14);

        // 2. key '5'
        base = pulse_cnt;
        pressed[key(1, 1)] = 1'b1;
        cyc(60);
        check("k5_pulses", 32'(pulse_cnt - base), 32'd1);
        check("k5_digito", 32'(digito), 32'd5);
        check("k5_eh", 32'(eh_digito), 32'd1);
        check("k5_col_held", 32'(colunas), 32'd13);
        pressed = '0;
        n = 0;
        while (colunas === 4'b1101 && n < 40) begin
            cyc(1);
            n++;
        end
        check("k5_release_latency", 32'(n), 32'd10);
        check("k5_no_extra", 32'(pulse_cnt - base), 32'd1);

        // 3. bouncing '8'
        base = pulse_cnt;
        for (int i = 0; i < 10; i++) begin
            pressed[key(2, 1)] = (i % 2 == 0);
            cyc(3);
        end
        check("k8_bounce_none", 32'(pulse_cnt - base), 32'd0);
        pressed[key(2, 1)] = 1'b1;
        cyc(40);
        check("k8_pulses", 32'(pulse_cnt - base), 32'd1);
        check("k8_digito", 32'(digito), 32'd8);
        pressed = '0;
        cyc(20);

        // 4. '#' then 'A'
        base = pulse_cnt;
        pressed[key(3, 2)] = 1'b1;
        cyc(40);
        check("khash_pulses", 32'(pulse_cnt - base), 32'd1);
        check("khash_digito", 32'(digito), 32'd15);
        check("khash_eh", 32'(eh_digito), 32'd0);
        pressed = '0;
        cyc(20);
        base = pulse_cnt;
        pressed[key(0, 3)] = 1'b1;
        cyc(40);
        check("kA_pulses", 32'(pulse_cnt - base), 32'd1);
        check("kA_digito", 32'(digito), 32'd10);
        check("kA_eh", 32'(eh_digito), 32'd0);
        pressed = '0;
        cyc(20);

        // 5. '0' with reset during FILTRA; align to the start of column 1's slot
        n = 0;
        while (colunas !== 4'b1110 && n < 20) begin
            cyc(1);
            n++;
        end
        n = 0;
        while (colunas !== 4'b1101 && n < 20) begin
            cyc(1);
            n++;
        end
        check("k0_align", 32'(colunas), 32'd13);
        base = pulse_cnt;
        pressed[key(3, 1)] = 1'b1;
        cyc(6);
        check("k0_filtra_no_pulse", 32'(pulse_cnt - base), 32'd0);
        reset = 1'b1;
        cyc(1);
        check("k0_rst_colunas", 32'(colunas), 32'd14);
        check("k0_rst_pulse", 32'(tecla_ativada), 32'd0);
        check("k0_rst_digito", 32'(digito), 32'd0);
        reset = 1'b0;
        cyc(15);
        check("k0_before_debounce", 32'(pulse_cnt - base), 32'd0);
        cyc(1);
        check("k0_pulse_on_time", 32'(tecla_ativada), 32'd1);
        check("k0_digito", 32'(digito), 32'd0);
        check("k0_eh", 32'(eh_digito), 32'd1);
        cyc(1);
        check("k0_pulse_one_cycle", 32'(tecla_ativada), 32'd0);
        check("k0_pulses", 32'(pulse_cnt - base), 32'd1);
        pressed = '0;
        cyc(20);

        // reset landing on the pulse cycle
        pressed[key(0, 2)] = 1'b1;
        n = 0;
        while (tecla_ativada !== 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        check("k3_pulse_seen", 32'(tecla_ativada), 32'd1);
        check("k3_digito", 32'(digito), 32'd3);
        reset = 1'b1;
        cyc(1);
        check("k3_rst_pulse", 32'(tecla_ativada), 32'd0);
        check("k3_rst_digito", 32'(digito), 32'd0);
        check("k3_rst_eh", 32'(eh_digito), 32'd0);
        pressed = '0;
        cyc(2);
        reset = 1'b0;
        cyc(2);

        // 6. '1' and '7' together in column 0
        base = pulse_cnt;
        pressed[key(0, 0)] = 1'b1;
        pressed[key(2, 0)] = 1'b1;
        cyc(40);
        check("k17_pulses", 32'(pulse_cnt - base), 32'd1);
        check("k17_digito", 32'(digito), 32'd1);
        pressed[key(0, 0)] = 1'b0;
        cyc(40);
        check("k17_partial_release", 32'(pulse_cnt - base), 32'd1);
        pressed = '0;
        cyc(20);
        pressed[key(2, 0)] = 1'b1;
        cyc(40);
        check("k7_repress_pulses", 32'(pulse_cnt - base), 32'd2);
        check("k7_digito", 32'(digito), 32'd7);
        pressed = '0;
        cyc(20);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
